// File: rtl/bram_burst_reader.sv
// rtl/bram_burst_reader.sv - burst reader: sequential BRAM reads into a credit-managed
// first-word-fall-through FIFO, drained on a valid/ready stream with a last-word flag.
module bram_burst_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   burst_len_i,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              dout_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   ret_q;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic             pop, push, issue;
  logic [OCC_W-1:0] inflight, occupancy;

  // Credit check counts words already in the FIFO plus reads still in the BRAM pipe,
  // so a read is only issued when a slot is guaranteed at its return edge.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(infl_q[i]);
    end
    pop       = dout_valid_o & dout_ready_i;
    push      = infl_q[RD_LAT-1];
    occupancy = OCC_W'(fifo_cnt_q) - OCC_W'(pop) + inflight;
    issue     = (state_q == S_READ) && (occupancy < OCC_W'(FIFO_DEPTH));
    infl_d    = infl_q << 1;
    infl_d[0] = issue;
  end

  assign ram_en_o     = issue;
  assign ram_addr_o   = addr_q;
  assign dout_valid_o = (fifo_cnt_q != '0);
  assign dout_o       = dout_valid_o ? mem_q[rd_ptr_q] : '0;
  assign dout_last_o  = dout_valid_o && ((ret_q + (ADDR_W+1)'(1)) == len_q);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ram_dout_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      ret_q      <= '0;
      infl_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      infl_q     <= infl_d;
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        ret_q    <= ret_q + (ADDR_W+1)'(1);
      end
      if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + (ADDR_W+1)'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q   <= start_addr_i;
            len_q    <= burst_len_i;
            issued_q <= '0;
            ret_q    <= '0;
            state_q  <= (burst_len_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (issue && (issued_q == len_q - (ADDR_W+1)'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && dout_last_o) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb/tb_bram_burst_reader.sv - directed bench for bram_burst_reader with a 2-cycle BRAM model.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  start_addr = '0;
  logic [4:0]  burst_len = '0;
  logic        ram_en;
  logic [3:0]  ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [16];
  logic [15:0] stage1;

  int checks = 0;
  int failures = 0;

  int first_valid, done_cyc, last_cyc, n_last, n_done, n_issue, n_issue_early;
  int stall_bad, max_occ, busy_after, busy_done, occ;
  logic [15:0] hold;
  logic        have_hold;
  logic [15:0] got[$];
  logic [15:0] addrs[$];

  bram_burst_reader #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
    .burst_len_i(burst_len), .ram_en_o(ram_en), .ram_addr_o(ram_addr),
    .ram_dout_i(ram_dout), .dout_o(dout), .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready), .dout_last_o(dout_last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Address registered on the enabled edge, data registered one edge later.
  always @(posedge clk) begin
    if (ram_en) stage1 <= mem[ram_addr];
    ram_dout <= stage1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int seq_err(input logic [15:0] q[$], input int base, input int len,
                                 input int off);
    int err = (q.size() != len) ? 1 : 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] !== 16'(((base + i) % 16) + off)) err++;
    end
    return err;
  endfunction

  // mode: 0 ready high, 1 ready low for 10 cycles, 2 random ready, 3 ready high plus a
  // stray start mid-burst. abort_after > 0 returns once that many words are accepted.
  task automatic run_burst(input logic [3:0] a, input logic [4:0] len, input int mode,
                           input int abort_after);
    first_valid = 0; done_cyc = 0; last_cyc = 0; n_last = 0; n_done = 0; n_issue = 0;
    n_issue_early = 0; stall_bad = 0; max_occ = 0; busy_after = -1; busy_done = -1;
    have_hold = 1'b0; hold = '0;
    got.delete(); addrs.delete();
    @(posedge clk); #1;
    start_addr = a; burst_len = len; start = 1'b1; dout_ready = (mode == 0 || mode == 3);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      occ = n_issue - got.size();
      if (occ > max_occ) max_occ = occ;
      if (ram_en) begin
        n_issue++;
        addrs.push_back(16'(ram_addr));
        if (c <= 10) n_issue_early++;
      end
      if (dout_valid && first_valid == 0) first_valid = c;
      if (dout_valid && !dout_ready) begin
        if (have_hold && dout !== hold) stall_bad++;
        hold = dout; have_hold = 1'b1;
      end else begin
        have_hold = 1'b0;
      end
      if (dout_valid && dout_ready) begin
        got.push_back(dout);
        if (dout_last) begin n_last++; last_cyc = c; end
      end
      if (done) begin
        n_done++;
        if (done_cyc == 0) begin done_cyc = c; busy_done = int'(busy); end
      end
      if (done_cyc != 0 && c == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      if (abort_after > 0 && got.size() == abort_after) return;
      @(posedge clk); #1;
      case (mode)
        1:       dout_ready = (c >= 10);
        2:       dout_ready = 1'($urandom_range(0, 1));
        3: begin
          dout_ready = 1'b1;
          start = (c == 5);
          start_addr = 4'd7; burst_len = 5'd2;
        end
        default: dout_ready = 1'b1;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 100);
    #12;
    chk("reset_outputs", int'({ram_en, ram_addr, dout, dout_valid, dout_last, busy, done}), 0);
    rst = 1'b1;

    run_burst(4'd0, 5'd16, 0, 0);
    chk("b16_data", seq_err(got, 0, 16, 100), 0);
    chk("b16_addr", seq_err(addrs, 0, 16, 0), 0);
    chk("b16_first_valid", first_valid, 4);
    chk("b16_last_cycle", last_cyc, 19);
    chk("b16_last_count", n_last, 1);
    chk("b16_done_cycle", done_cyc, 20);
    chk("b16_done_count", n_done, 1);
    chk("b16_busy_after", busy_after, 0);

    run_burst(4'd14, 5'd4, 0, 0);
    chk("wrap_addr", seq_err(addrs, 14, 4, 0), 0);
    chk("wrap_data", seq_err(got, 14, 4, 100), 0);
    chk("wrap_last_cycle", last_cyc, 7);
    chk("wrap_done_cycle", done_cyc, 8);

    run_burst(4'd0, 5'd16, 1, 0);
    chk("stall_early_issues", n_issue_early, 4);
    chk("stall_max_occ", max_occ, 4);
    chk("stall_hold", stall_bad, 0);
    chk("stall_data", seq_err(got, 0, 16, 100), 0);
    chk("stall_addr", seq_err(addrs, 0, 16, 0), 0);

    run_burst(4'd0, 5'd16, 2, 0);
    chk("rand_data", seq_err(got, 0, 16, 100), 0);
    chk("rand_addr", seq_err(addrs, 0, 16, 0), 0);
    chk("rand_occ_le4", int'(max_occ <= 4), 1);
    chk("rand_hold", stall_bad, 0);
    chk("rand_last_count", n_last, 1);

    run_burst(4'd0, 5'd16, 3, 0);
    chk("restart_data", seq_err(got, 0, 16, 100), 0);
    chk("restart_addr", seq_err(addrs, 0, 16, 0), 0);
    chk("restart_done_cycle", done_cyc, 20);

    run_burst(4'd5, 5'd0, 0, 0);
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_busy_with_done", busy_done, 1);
    chk("zero_busy_after", busy_after, 0);
    chk("zero_issues", n_issue, 0);
    chk("zero_valid", first_valid, 0);

    run_burst(4'd0, 5'd16, 0, 5);
    chk("abort_words_before", got.size(), 5);
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", int'({ram_en, ram_addr, dout, dout_valid, dout_last, busy, done}), 0);
    @(negedge clk);
    rst = 1'b1;

    run_burst(4'd0, 5'd3, 0, 0);
    chk("post_abort_data", seq_err(got, 0, 3, 100), 0);
    chk("post_abort_last_count", n_last, 1);
    chk("post_abort_done_cycle", done_cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_burst_reader.md
# bram_burst_reader

Read-side burst controller for the block-RAM test path. On a start pulse it issues a burst of sequential reads to a single-port BRAM with fixed read latency, buffers the returning words in a small credit-managed FIFO, and presents them on a valid/ready stream with a last-word flag. It sits on the opposite side of the BRAM from the burst writer. After a 16-word write burst completes, it drains the stored words toward the result logger or the next processing stage.

## Interface
- DATA_W, 16, BRAM and stream word width
- ADDR_W, 4, BRAM address width; depth = 2^ADDR_W
- RD_LAT, 2, BRAM read latency in clocks (1 or 2), from the edge that samples ram_addr to data valid on ram_dout
- FIFO_DEPTH, 4, output buffer depth in words (power of two, ≥ RD_LAT+2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle burst request; sampled only in IDLE
- start_addr  in  ADDR_W  first BRAM address of the burst
- burst_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- ram_en  out  1  BRAM read enable
- ram_addr  out  ADDR_W  BRAM read address
- ram_dout  in  DATA_W  BRAM read data
- dout  out  DATA_W  stream data
- dout_valid  out  1  stream valid
- dout_ready  in  1  stream ready
- dout_last  out  1  high with the final word of the burst
- busy  out  1  high from the start-accept edge until the done pulse
- done  out  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE → READ on start with burst_len ≠ 0. On that edge, capture start_addr and burst_len, and clear the issue and return counters.
- IDLE → DONE on start with burst_len = 0. No reads are issued and no stream word is produced.
- A start seen outside IDLE is ignored. start_addr and burst_len are not used after capture.
- READ:
  - Issue a read (ram_en=1, ram_addr=current) when (fifo_count − pop_this_cycle + inflight) < FIFO_DEPTH. Otherwise ram_en=0.
  - After each issue, the address increments modulo 2^ADDR_W. Wrap from 2^ADDR_W−1 to 0 is required.
  - READ → DRAIN on the edge that issues the burst_len-th read.
- inflight is tracked with an RD_LAT-deep shift register of issue flags. ram_dout is written into the FIFO on the edge where the flag exits the shift register.
- The FIFO is first-word-fall-through: dout/dout_valid reflect the head entry, and a pop occurs when dout_valid & dout_ready.
- dout_last is high when the head entry is word burst_len of the burst. The index is tracked by a return counter.
- DRAIN → DONE on the handshake of the last word.
- DONE: done=1 for one cycle, then → IDLE. busy is low in IDLE only.
- dout and dout_valid are stable while dout_valid=1 and dout_ready=0. The FIFO never overflows.

## Timing
- Reset (rst=0, asynchronous) gives: state=IDLE, ram_en=0, ram_addr=0, dout=0, dout_valid=0, dout_last=0, busy=0, done=0, FIFO empty, inflight cleared. Reset in any state aborts the burst immediately. The first start is accepted on the first rising edge with rst=1.
- The start-accept edge is E0. ram_en is first high in the cycle after E0. The BRAM samples at E1. The word is written at E(1+RD_LAT). dout_valid is first high after edge E(1+RD_LAT).
- With dout_ready held high, throughput is one word per clock. An N-word burst completes its last handshake at edge E(N+RD_LAT+1). done is high in the following cycle. busy falls with done.
- With dout_ready low, at most FIFO_DEPTH words are buffered and issue stalls, so ram_en stays low. Issue resumes the cycle after space is freed.
- busy rises after E0. A burst_len=0 start gives busy and done high for exactly one cycle (the DONE cycle), then IDLE.

## Test plan
- Reset, then preload BRAM[a]=a+100. Pulse start with start_addr=0, burst_len=16, dout_ready=1 → dout 100..115 on 16 consecutive cycles, the first valid after E3 (RD_LAT=2), dout_last only on 115, and done one cycle after the last handshake.
- Pulse start with start_addr=14, burst_len=4 → ram_addr sequence 14, 15, 0, 1 and dout 114, 115, 100, 101.
- Hold dout_ready=0 for 10 cycles after start with burst_len=16 → ram_en issues exactly 4 reads then stays low, dout holds 100 steadily. Release ready → full sequence with no loss or duplication.
- Toggle dout_ready randomly at 50% over a 16-word burst → output equals 100..115 in order. Check that fifo_count+inflight never exceeds 4.
- Pulse start again while busy (mid-burst) → ignored, with the burst unchanged. Pulse start with burst_len=0 → done pulse, no ram_en, no dout_valid.
- Assert rst=0 asynchronously mid-burst (after 5 words) → all outputs 0 immediately. The next start with burst_len=3 yields a clean 3-word burst.
